// File: rtl/axi_mem_pkg.sv
// Shared constants and types for the AXI4 write-target memory model.
package axi_mem_pkg;

    localparam int unsigned DEF_DATA_W = 512;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_ID_W   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

endpackage

// File: rtl/axi_mem_bram.sv
// Single-port byte-enabled write RAM with an asynchronous debug read port.
module axi_mem_bram #(
    parameter  int unsigned DATA_W    = 512,
    parameter  int unsigned MEM_DEPTH = 4096,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH),
    localparam int unsigned STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read-before-write: a same-cycle write only becomes visible after the edge.
    assign o_dbg_rdata = r_mem[i_dbg_addr];

endmodule

// File: rtl/axi_mem_wr_target.sv
// AXI4 write-channel slave memory model: single outstanding INCR burst,
// burst length taken from AWLEN, WLAST misplacement reported as SLVERR.
module axi_mem_wr_target
    import axi_mem_pkg::*;
#(
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned ADDR_W    = DEF_ADDR_W,
    parameter  int unsigned ID_W      = DEF_ID_W,
    parameter  int unsigned MEM_DEPTH = 4096,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH),
    localparam int unsigned STRB_W    = DATA_W / 8,
    localparam int unsigned BYTE_OFF  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [ID_W-1:0]   AWID,
    input  logic [7:0]        AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ID_W-1:0]   WID,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [ID_W-1:0]   r_id, w_id_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              r_awready, r_wready, r_bvalid;
    logic [ID_W-1:0]   r_bid, w_bid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
    logic              w_we;
    logic              w_beat_err;
    logic              w_unused;

    assign w_unused = ^{WID, AWADDR[BYTE_OFF-1:0], AWADDR[ADDR_W-1:BYTE_OFF+IDX_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_id_nxt    = r_id;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_bid_nxt   = r_bid;
        w_bresp_nxt = r_bresp;
        w_we        = 1'b0;
        w_beat_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (AWVALID && r_awready) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = AWADDR[BYTE_OFF +: IDX_W];
                    w_id_nxt    = AWID;
                    w_cnt_nxt   = AWLEN;
                    w_err_nxt   = 1'b0;
                end
            end
            DATA: begin
                if (WVALID && r_wready) begin
                    w_we       = 1'b1;
                    w_idx_nxt  = r_idx + IDX_W'(1);
                    // WLAST must be high exactly on the beat where the down-counter hits zero.
                    w_beat_err = (r_cnt == 8'd0) ? !WLAST : WLAST;
                    w_err_nxt  = r_err | w_beat_err;
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = RESP;
                        w_bid_nxt   = r_id;
                        w_bresp_nxt = (r_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            RESP: begin
                if (BREADY) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_id      <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_id      <= w_id_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= w_err_nxt;
            r_awready <= (w_state_nxt == IDLE);
            r_wready  <= (w_state_nxt == DATA);
            r_bvalid  <= (w_state_nxt == RESP);
            r_bid     <= w_bid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BID     = r_bid;
    assign BRESP   = r_bresp;

    axi_mem_bram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_bram (
        .clk         (clk),
        .i_we        (w_we),
        .i_idx       (r_idx),
        .i_wdata     (WDATA),
        .i_wstrb     (WSTRB),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_axi_mem_wr_target.sv
// Directed plus randomized bench for axi_mem_wr_target against a byte-level memory model.
module tb_axi_mem_wr_target;

    localparam int unsigned DATA_W    = 512;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned MEM_DEPTH = 4096;
    localparam int unsigned IDX_W     = 12;
    localparam int unsigned STRB_W    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] AWADDR;
    logic [ID_W-1:0]   AWID;
    logic [7:0]        AWLEN;
    logic              AWVALID;
    logic              AWREADY;
    logic [ID_W-1:0]   WID;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [IDX_W-1:0]  dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference memory: data plus a per-byte "known" mask for bytes the bench has written.
    logic [DATA_W-1:0] m_data  [int];
    logic [STRB_W-1:0] m_known [int];

    // Beats for the next burst.
    logic [DATA_W-1:0] q_data [$];
    logic [STRB_W-1:0] q_strb [$];
    logic              q_last [$];

    axi_mem_wr_target #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .AWADDR    (AWADDR),
        .AWID      (AWID),
        .AWLEN     (AWLEN),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] k);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < STRB_W; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    function automatic void model_write(input int idx, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m;
        if (!m_data.exists(idx)) begin
            m_data[idx]  = '0;
            m_known[idx] = '0;
        end
        m = byte_mask(s);
        m_data[idx]  = (m_data[idx] & ~m) | (d & m);
        m_known[idx] = m_known[idx] | s;
    endfunction

    task automatic check_mem(input string tag, input int idx);
        logic [DATA_W-1:0] m;
        dbg_addr = IDX_W'(idx);
        @(negedge clk);
        m = byte_mask(m_known[idx]);
        check(tag, dbg_rdata & m, m_data[idx] & m);
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input logic l);
        q_data.push_back(d);
        q_strb.push_back(s);
        q_last.push_back(l);
    endtask

    // gap_mode: 0 = back-to-back beats, 1 = one idle cycle before each beat, 2 = random 0..2 idle cycles.
    task automatic run_burst(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                             input logic [7:0] len, input int gap_mode, input int bp_cycles);
        int idx;
        int budget;
        int gaps;
        bit err;
        logic [1:0] exp_resp;
        idx = int'((addr >> 6) % MEM_DEPTH);
        err = 1'b0;

        AWADDR  = addr;
        AWID    = id;
        AWLEN   = len;
        AWVALID = 1'b1;
        budget  = 0;
        while (!AWREADY && budget < 50) begin
            tick();
            budget++;
        end
        check("aw_ready", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        AWADDR  = $urandom;
        AWID    = ID_W'($urandom);
        AWLEN   = 8'($urandom);
        check("wready_after_aw", WREADY, 1);
        check("awready_in_data", AWREADY, 0);

        for (int beat = 0; beat <= int'(len); beat++) begin
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                WVALID = 1'b0;
                WDATA  = rand_word();
                WSTRB  = '1;
                WLAST  = 1'($urandom);
                tick();
            end
            WVALID = 1'b1;
            WID    = ID_W'($urandom);
            WDATA  = q_data[beat];
            WSTRB  = q_strb[beat];
            WLAST  = q_last[beat];
            budget = 0;
            while (!WREADY && budget < 50) begin
                tick();
                budget++;
            end
            if (!WREADY) check("w_ready_timeout", WREADY, 1);
            tick();
            model_write(idx, q_data[beat], q_strb[beat]);
            idx = (idx + 1) % MEM_DEPTH;
            if (q_last[beat] != (beat == int'(len))) err = 1'b1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        q_data.delete();
        q_strb.delete();
        q_last.delete();

        exp_resp = err ? 2'b10 : 2'b00;
        check("bvalid", BVALID, 1);
        check("bid", BID, id);
        check("bresp", BRESP, exp_resp);
        check("wready_in_resp", WREADY, 0);
        for (int c = 0; c < bp_cycles; c++) begin
            tick();
            check("bp_bvalid", BVALID, 1);
            check("bp_bid", BID, id);
            check("bp_bresp", BRESP, exp_resp);
            check("bp_awready", AWREADY, 0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_cleared", BVALID, 0);
        check("awready_back", AWREADY, 1);
        tick();
        check("single_b", BVALID, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] exp_w;
        logic [ADDR_W-1:0] ra;
        logic [7:0]        rl;
        bit                bad;
        int                bad_beat;

        reset = 1'b1; AWADDR = '0; AWID = '0; AWLEN = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; dbg_addr = '0;

        // Reset and release
        repeat (3) tick();
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bid", BID, 0);
        check("rst_bresp", BRESP, 0);
        reset = 1'b0;
        tick();
        check("rel_awready", AWREADY, 1);
        check("rel_wready", WREADY, 0);
        check("rel_bvalid", BVALID, 0);

        // Single beat at word 1
        push_beat({64{8'hA5}}, '1, 1'b1);
        run_burst(32'h40, 4'd3, 8'd0, 0, 0);
        check_mem("single_mem1", 1);
        dbg_addr = 12'd1;
        @(negedge clk);
        check("single_a5", dbg_rdata, {64{8'hA5}});

        // 64 beats at word 64, WVALID toggling
        for (int i = 0; i < 64; i++) push_beat(DATA_W'(i), '1, i == 63);
        run_burst(32'h1000, 4'd7, 8'd63, 1, 0);
        for (int i = 0; i < 64; i++) begin
            dbg_addr = IDX_W'(64 + i);
            @(negedge clk);
            check("burst64", dbg_rdata, DATA_W'(i));
        end

        // Partial strobe on word 2
        push_beat({64{8'hFF}}, '1, 1'b1);
        run_burst(32'h80, 4'd1, 8'd0, 0, 0);
        push_beat('0, 64'h0000_0000_0000_000F, 1'b1);
        run_burst(32'h80, 4'd2, 8'd0, 0, 0);
        dbg_addr = 12'd2;
        @(negedge clk);
        exp_w = {{60{8'hFF}}, 32'h0};
        check("partial_strb", dbg_rdata, exp_w);

        // Early WLAST on a non-final beat, then a clean burst
        for (int i = 0; i < 4; i++) push_beat(rand_word(), '1, i == 1);
        run_burst(32'h2000, 4'd5, 8'd3, 0, 0);
        for (int i = 0; i < 4; i++) check_mem("wlast_err_mem", 128 + i);
        for (int i = 0; i < 2; i++) push_beat(rand_word(), '1, i == 1);
        run_burst(32'h2100, 4'd6, 8'd1, 0, 0);

        // Missing WLAST on final beat
        for (int i = 0; i < 3; i++) push_beat(rand_word(), '1, 1'b0);
        run_burst(32'h3000, 4'd9, 8'd2, 0, 0);

        // Backpressure, then index wrap at MEM_DEPTH-1
        push_beat(rand_word(), '1, 1'b1);
        run_burst(32'h4000, 4'd12, 8'd0, 0, 10);
        for (int i = 0; i < 2; i++) push_beat(rand_word(), '1, i == 1);
        run_burst(32'((MEM_DEPTH - 1) * 64), 4'd4, 8'd1, 0, 0);
        check_mem("wrap_last", MEM_DEPTH - 1);
        check_mem("wrap_first", 0);

        // Upper address bits wrap modulo MEM_DEPTH; byte offset ignored
        push_beat(rand_word(), '1, 1'b1);
        run_burst(32'h0004_0000 + 32'h140 + 32'h1F, 4'd10, 8'd0, 0, 0);
        check_mem("addr_wrap", 5);

        // Randomized bursts
        for (int n = 0; n < 12; n++) begin
            ra       = $urandom;
            rl       = 8'($urandom_range(0, 7));
            bad      = ($urandom_range(0, 3) == 0);
            bad_beat = $urandom_range(0, int'(rl));
            for (int i = 0; i <= int'(rl); i++) begin
                push_beat(rand_word(), {$urandom, $urandom},
                          (i == int'(rl)) ^ (bad && i == bad_beat));
            end
            run_burst(ra, ID_W'($urandom), rl, 2, $urandom_range(0, 3));
        end

        // Erroneous burst leaves nonzero BID/BRESP before reset test
        push_beat(rand_word(), '1, 1'b0);
        run_burst(32'h5000, 4'd14, 8'd0, 0, 0);

        // Reset in the middle of a burst
        AWADDR = 32'(200 * 64); AWID = 4'd11; AWLEN = 8'd5; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_w  = rand_word();
            WVALID = 1'b1; WDATA = exp_w; WSTRB = '1; WLAST = 1'b0;
            tick();
            model_write(200 + i, exp_w, '1);
        end
        WVALID = 1'b0;
        check("mid_wready", WREADY, 1);
        reset = 1'b1;
        tick();
        check("midrst_awready", AWREADY, 0);
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_bid", BID, 0);
        check("midrst_bresp", BRESP, 0);
        reset = 1'b0;
        tick();
        check("midrst_awready_back", AWREADY, 1);
        check_mem("midrst_kept0", 200);
        check_mem("midrst_kept1", 201);
        for (int i = 0; i < 3; i++) push_beat(rand_word(), '1, i == 2);
        run_burst(32'(300 * 64), 4'd8, 8'd2, 0, 0);

        // Full sweep of every word the model knows about
        foreach (m_known[k]) check_mem("sweep", k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_wr_target.md
Name: axi_mem_wr_target

Overview:
- AXI4 write-channel slave memory model.
- Accepts single-outstanding INCR write bursts from the external-memory traffic generator and stores the data in an internal 512-bit-wide byte-enabled array.
- Returns one B response per burst.
- Stands in for the DDR4 controller's write port in simulation. A debug read port lets the bench check stored contents.

Parameters:
- DATA_W, 512, data bus width in bits (multiple of 8).
- ADDR_W, 32, AXI address width.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 4096, number of DATA_W-bit words (power of 2).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_W  byte address of the burst.
- AWID  in  ID_W  burst ID.
- AWLEN  in  8  beats minus 1.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address accepted.
- WID  in  ID_W  ignored.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte enables.
- WLAST  in  1  last beat marker.
- WVALID  in  1  data valid.
- WREADY  out  1  data accepted.
- BID  out  ID_W  response ID.
- BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- BVALID  out  1  response valid.
- BREADY  in  1  response accepted.
- dbg_addr  in  log2(MEM_DEPTH)  word index for backdoor read.
- dbg_rdata  out  DATA_W  mem[dbg_addr], combinational.

Behaviour:
- All control outputs are registered.
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, state=IDLE. Memory contents are not cleared.
- AWREADY rises on the first clk edge after reset deasserts.
- FSM states:
  - IDLE: AWREADY=1. An AW handshake (AWVALID & AWREADY) latches:
    - word index = AWADDR[6 +: log2(MEM_DEPTH)] (byte offset bits [5:0] ignored; upper bits wrap modulo MEM_DEPTH);
    - ID;
    - beat count = AWLEN.
    On the next edge: AWREADY=0, WREADY=1, go to DATA.
  - DATA: WREADY=1. Each W handshake writes the WSTRB-enabled bytes of WDATA to mem[idx]; idx increments by 1, wrapping at MEM_DEPTH.
    - The beat counter counts down. When the handshake occurs on beat AWLEN+1: WREADY=0, BVALID=1, BID=latched ID, go to RESP.
    - Burst length is defined by AWLEN only; WLAST does not terminate the burst.
    - If WLAST=1 on a non-final beat, or WLAST=0 on the final beat, a sticky error flag is set and BRESP=SLVERR. Otherwise BRESP=OKAY.
  - RESP: hold BVALID, BID and BRESP stable until BREADY=1. On that edge: BVALID=0, clear the error flag, AWREADY=1, go to IDLE.
- Only one burst is outstanding. AWVALID is not accepted in DATA or RESP.
- WVALID=0 in DATA stalls with no write.
- WID is ignored.
- Reset mid-burst: the FSM returns to IDLE and outputs take their reset values. Words already written stay written.
- A backdoor write and a debug read to the same index in the same cycle: dbg_rdata shows the old value until the edge.
- Throughput: one beat per cycle. Burst overhead is 1 cycle for AW plus 1 cycle for B when BREADY is held high.

Decomposition:
- Package axi_mem_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - state enum {IDLE, DATA, RESP};
  - default width constants (DATA_W, ID_W, ADDR_W).
- One sub-module, axi_mem_bram: a single-port byte-enable write RAM (MEM_DEPTH x DATA_W) with an asynchronous debug read port.
- The top-level holds the FSM, counters and response logic.

Test Plan:
- Reset release: after reset falls, AWREADY=1 on the next cycle; WREADY=0 and BVALID=0 until an AW handshake.
- Single beat: AWADDR=0x40, AWLEN=0, AWID=3; one W beat with WDATA=all 0xA5 bytes, WSTRB all ones, WLAST=1. Required: mem[1]=0xA5.., BVALID with BID=3, BRESP=OKAY.
- 64-beat burst at AWADDR=0x1000 with data = beat number and WVALID toggling every other cycle. Required: mem[64..127] = 0..63, exactly one B response, and no writes on cycles where WVALID=0.
- Partial strobe: pre-fill mem[2]=all 0xFF, then write AWADDR=0x80 with WSTRB=0x0000_0000_0000_000F and WDATA=0. Required: only bytes 0..3 of mem[2] become 0x00.
- WLAST error: AWLEN=3 with WLAST asserted on beat 2. Required: 4 beats accepted, BRESP=SLVERR. The following clean burst returns OKAY.
- Backpressure and wrap: hold BREADY=0 for 10 cycles; BVALID, BID and BRESP stay stable and AWREADY stays 0. Then a burst at word index MEM_DEPTH-1 with AWLEN=1 writes mem[MEM_DEPTH-1] and mem[0].
